// File: rtl/periph_bridge_pkg.sv
// Shared types for the peripheral bridge: store-type encoding used on both
// the core-side and the peripheral-side buses.
package periph_bridge_pkg;

    // Zero means load; any nonzero value is a write of the given size.
    typedef enum logic [2:0] {
        STORE_NONE  = 3'd0,
        STORE_BYTE  = 3'd1,
        STORE_HALF  = 3'd2,
        STORE_WORD  = 3'd3,
        STORE_DWORD = 3'd4
    } mem_store_type_t;

endpackage

// File: rtl/periph_bridge_if.sv
// Bus interfaces for the peripheral bridge: one core-side request/response
// channel and one fan-out channel to NUM_PORTS peripherals.

// Core-side data channel. The core is the master; the bridge is the slave.
interface periph_core_if;
    import periph_bridge_pkg::*;

    logic [63:0]     d_addr;
    logic [63:0]     d_wdata;
    mem_store_type_t d_store_type;
    logic            d_valid;
    logic            d_ready;
    logic [63:0]     d_rdata;
    logic            d_error;

    modport master (
        output d_addr, d_wdata, d_store_type, d_valid,
        input  d_ready, d_rdata, d_error
    );

    modport slave (
        input  d_addr, d_wdata, d_store_type, d_valid,
        output d_ready, d_rdata, d_error
    );
endinterface

// Peripheral-side channel. Address, data and store type are shared by all
// ports; valid is one-hot, ready and read data are per port.
interface periph_port_if #(
    parameter int NUM_PORTS = 4
);
    import periph_bridge_pkg::*;

    logic [NUM_PORTS-1:0]    p_valid;
    logic [63:0]             p_addr;
    logic [63:0]             p_wdata;
    mem_store_type_t         p_store_type;
    logic [NUM_PORTS-1:0]    p_ready;
    logic [NUM_PORTS*64-1:0] p_rdata;

    modport master (
        output p_valid, p_addr, p_wdata, p_store_type,
        input  p_ready, p_rdata
    );

    modport slave (
        input  p_valid, p_addr, p_wdata, p_store_type,
        output p_ready, p_rdata
    );
endinterface

// File: rtl/periph_bridge.sv
// Peripheral bridge: decodes a core data request into one of NUM_PORTS
// address windows, forwards it to that port, waits for completion or a
// timeout, and returns a one-cycle completion pulse with data and error.
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter int          NUM_PORTS       = 4,
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int          PORT_SPAN_LOG2  = 12,
    parameter int          TIMEOUT         = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    periph_core_if.slave         core,
    periph_port_if.master        pbus,
    output logic [15:0]          timeout_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    mem_store_type_t st_q, st_d;
    logic [3:0]      sel_q, sel_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            error_q, error_d;
    logic [15:0]     tcount_q, tcount_d;

    // Address decode is done on the live core address at acceptance time;
    // the subtraction wraps for addresses below base, hence the explicit check.
    logic [63:0] offset;
    logic [63:0] idx_full;
    logic        decode_miss;

    assign offset      = core.d_addr - PERIPHERAL_BASE;
    assign idx_full    = offset >> PORT_SPAN_LOG2;
    assign decode_miss = (core.d_addr < PERIPHERAL_BASE) || (idx_full >= 64'(NUM_PORTS));

    // Per-port select, ready qualification and read-data steering.
    logic [NUM_PORTS-1:0] sel_onehot;
    logic [63:0]          slice_masked [NUM_PORTS];
    logic [63:0]          sel_rdata;
    logic                 sel_ready;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign sel_onehot[gi]   = (sel_q == 4'(gi));
        assign slice_masked[gi] = sel_onehot[gi] ? pbus.p_rdata[gi*64 +: 64] : 64'd0;
    end

    // Only the selected port's ready counts; other ports are ignored.
    assign sel_ready = |(pbus.p_ready & sel_onehot);

    // OR-combine the masked slices; at most one is nonzero.
    always_comb begin
        sel_rdata = 64'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_rdata = sel_rdata | slice_masked[i];
        end
    end

    // Next-state and datapath updates for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        st_d     = st_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        tcount_d = tcount_q;

        case (state_q)
            IDLE: begin
                if (core.d_valid) begin
                    addr_d  = core.d_addr;
                    wdata_d = core.d_wdata;
                    st_d    = core.d_store_type;
                    cnt_d   = 16'd0;
                    if (decode_miss) begin
                        rdata_d = 64'd0;
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        sel_d   = idx_full[3:0];
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                // Ready takes priority over a timeout landing on the same edge.
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    error_d = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    rdata_d = 64'hFFFF_FFFF_FFFF_FFFF;
                    error_d = 1'b1;
                    if (tcount_q != 16'hFFFF) begin
                        tcount_d = tcount_q + 16'd1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DONE: begin
                // New requests are only looked at in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            st_q     <= STORE_NONE;
            sel_q    <= 4'd0;
            cnt_q    <= 16'd0;
            rdata_q  <= 64'd0;
            error_q  <= 1'b0;
            tcount_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            st_q     <= st_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            tcount_q <= tcount_d;
        end
    end

    // Outputs are decoded from registered state only, so reset clears
    // p_valid and d_ready without waiting for a clock edge.
    assign pbus.p_valid      = (state_q == BUSY) ? sel_onehot : '0;
    assign pbus.p_addr       = addr_q;
    assign pbus.p_wdata      = wdata_q;
    assign pbus.p_store_type = st_q;

    assign core.d_ready = (state_q == DONE);
    assign core.d_rdata = rdata_q;
    assign core.d_error = error_q;

    assign timeout_count = tcount_q;

endmodule

// File: tb/tb_periph_bridge.sv
// Directed bench for periph_bridge with NUM_PORTS=4 and TIMEOUT=4.
module tb_periph_bridge;
    import periph_bridge_pkg::*;

    localparam int NP = 4;
    localparam int TO = 4;

    logic        clock;
    logic        reset;
    logic [15:0] timeout_count;

    periph_core_if                   core ();
    periph_port_if #(.NUM_PORTS(NP)) pbus ();

    periph_bridge #(
        .NUM_PORTS       (NP),
        .PERIPHERAL_BASE (64'h2000_0000),
        .PORT_SPAN_LOG2  (12),
        .TIMEOUT         (TO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .core          (core),
        .pbus          (pbus),
        .timeout_count (timeout_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ready_cyc: BUSY cycle (1-based) in which the selected port asserts ready;
    // 0 means never. noise drives ready on every non-selected port.
    typedef struct {
        logic [63:0]     addr;
        logic [63:0]     wdata;
        mem_store_type_t st;
        int              ready_cyc;
        bit              noise;
        logic [3:0]      exp_pv;
        logic [63:0]     exp_rdata;
        logic            exp_err;
        int              exp_lat;
        logic [15:0]     exp_tc;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vec(input int id, input vec_t v);
        int cyc;
        core.d_addr       = v.addr;
        core.d_wdata      = v.wdata;
        core.d_store_type = v.st;
        core.d_valid      = 1'b1;
        step();
        core.d_valid = 1'b0;
        cyc = 1;
        chk("p_valid_t1", 64'(pbus.p_valid), 64'(v.exp_pv));
        while (core.d_ready !== 1'b1 && cyc < 12) begin
            chk("p_valid_busy", 64'(pbus.p_valid), 64'(v.exp_pv));
            chk("p_addr_busy", pbus.p_addr, v.addr);
            chk("p_wdata_busy", pbus.p_wdata, v.wdata);
            chk("p_st_busy", 64'(pbus.p_store_type), 64'(v.st));
            pbus.p_ready = (v.noise ? ~v.exp_pv : 4'b0000) |
                           ((cyc == v.ready_cyc) ? v.exp_pv : 4'b0000);
            step();
            cyc++;
        end
        pbus.p_ready = '0;
        chk("d_ready", 64'(core.d_ready), 64'd1);
        chk("latency", 64'(cyc), 64'(v.exp_lat));
        chk("d_rdata", core.d_rdata, v.exp_rdata);
        chk("d_error", 64'(core.d_error), 64'(v.exp_err));
        chk("p_valid_done", 64'(pbus.p_valid), 64'd0);
        chk("timeout_count", 64'(timeout_count), 64'(v.exp_tc));
        step();
        chk("d_ready_pulse", 64'(core.d_ready), 64'd0);
        chk("d_rdata_hold", core.d_rdata, v.exp_rdata);
        chk("d_error_hold", 64'(core.d_error), 64'(v.exp_err));
        $display("vec %0d addr=%h pv=%b lat=%0d rdata=%h err=%0d tc=%0d",
                 id, v.addr, v.exp_pv, cyc, core.d_rdata, core.d_error, timeout_count);
    endtask

    initial begin
        // addr, wdata, st, ready_cyc, noise, exp_pv, exp_rdata, exp_err, exp_lat, exp_tc
        vecs[0]  = '{64'h2000_1008, 64'h0, STORE_NONE, 3, 1'b0, 4'b0010,
                     64'h0000_0000_0000_DEAD, 1'b0, 4, 16'd0};
        vecs[1]  = '{64'h2000_3000, 64'h55, STORE_DWORD, 2, 1'b1, 4'b1000,
                     64'hFEED_FACE_CAFE_0003, 1'b0, 3, 16'd0};
        vecs[2]  = '{64'h2000_4000, 64'h0, STORE_NONE, 0, 1'b0, 4'b0000,
                     64'h0, 1'b1, 1, 16'd0};
        vecs[3]  = '{64'h1000_0000, 64'h0, STORE_NONE, 0, 1'b0, 4'b0000,
                     64'h0, 1'b1, 1, 16'd0};
        vecs[4]  = '{64'h2000_0FF8, 64'h0, STORE_NONE, 1, 1'b0, 4'b0001,
                     64'hA0A0_0000_0000_0000, 1'b0, 2, 16'd0};
        vecs[5]  = '{64'h2000_2ABC, 64'h77, STORE_WORD, 0, 1'b1, 4'b0100,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5, 16'd1};
        vecs[6]  = '{64'h2000_2000, 64'h0, STORE_NONE, 4, 1'b0, 4'b0100,
                     64'h0123_4567_89AB_CDEF, 1'b0, 5, 16'd1};
        vecs[7]  = '{64'h2000_0000, 64'h1234, STORE_BYTE, 1, 1'b1, 4'b0001,
                     64'hA0A0_0000_0000_0000, 1'b0, 2, 16'd1};
        vecs[8]  = '{64'h1FFF_FFFF, 64'h0, STORE_NONE, 0, 1'b0, 4'b0000,
                     64'h0, 1'b1, 1, 16'd1};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_F000, 64'h0, STORE_HALF, 0, 1'b0, 4'b0000,
                     64'h0, 1'b1, 1, 16'd1};
        vecs[10] = '{64'h2000_3FF0, 64'h0, STORE_NONE, 0, 1'b0, 4'b1000,
                     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5, 16'd2};

        core.d_addr       = '0;
        core.d_wdata      = '0;
        core.d_store_type = STORE_NONE;
        core.d_valid      = 1'b0;
        pbus.p_ready      = '0;
        pbus.p_rdata      = {64'hFEED_FACE_CAFE_0003, 64'h0123_4567_89AB_CDEF,
                             64'h0000_0000_0000_DEAD, 64'hA0A0_0000_0000_0000};

        // Reset state.
        reset = 1'b0;
        step();
        step();
        chk("rst_p_valid", 64'(pbus.p_valid), 64'd0);
        chk("rst_d_ready", 64'(core.d_ready), 64'd0);
        chk("rst_d_rdata", core.d_rdata, 64'd0);
        chk("rst_d_error", 64'(core.d_error), 64'd0);
        chk("rst_tc", 64'(timeout_count), 64'd0);
        chk("rst_p_addr", pbus.p_addr, 64'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back: d_valid held high through DONE must not be taken
        // until the bridge is back in IDLE.
        core.d_addr       = 64'h2000_1010;
        core.d_store_type = STORE_NONE;
        core.d_valid      = 1'b1;
        pbus.p_ready      = 4'b0010;
        step();
        chk("b2b_busy1", 64'(pbus.p_valid), 64'b0010);
        step();
        chk("b2b_done1", 64'(core.d_ready), 64'd1);
        chk("b2b_rdata1", core.d_rdata, 64'hDEAD);
        step();
        chk("b2b_gap_pv", 64'(pbus.p_valid), 64'd0);
        chk("b2b_gap_rdy", 64'(core.d_ready), 64'd0);
        step();
        chk("b2b_busy2", 64'(pbus.p_valid), 64'b0010);
        core.d_valid = 1'b0;
        step();
        chk("b2b_done2", 64'(core.d_ready), 64'd1);
        pbus.p_ready = '0;
        step();
        $display("b2b sequence done tc=%0d", timeout_count);

        // Reset in the middle of BUSY clears everything without a clock edge.
        core.d_addr  = 64'h2000_1000;
        core.d_valid = 1'b1;
        step();
        core.d_valid = 1'b0;
        chk("mid_busy_pv", 64'(pbus.p_valid), 64'b0010);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pv", 64'(pbus.p_valid), 64'd0);
        chk("async_rst_tc", 64'(timeout_count), 64'd0);
        chk("async_rst_rdata", core.d_rdata, 64'd0);
        chk("async_rst_err", 64'(core.d_error), 64'd0);
        chk("async_rst_rdy", 64'(core.d_ready), 64'd0);
        chk("async_rst_addr", pbus.p_addr, 64'd0);
        step();
        reset = 1'b1;
        step();
        chk("post_rst_pv", 64'(pbus.p_valid), 64'd0);
        chk("post_rst_rdy", 64'(core.d_ready), 64'd0);
        $display("mid-BUSY reset sequence done");
        run_vec(11, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
